seq_alu: RTL and testbench

Multi-cycle, parametrised successor of the t16q core ALU. Accepts one operation per transaction over a valid/ready handshake and returns a registered result with z/c/n/v flags. Single-cycle arithmetic/logic ops sit beside an iterative shifter with a signed shift amount and an optional iterative multiplier. It sits between the decode/register-read stage and writeback; the pipeline stalls on `in_ready`/`out_valid`.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_core.sv | 55 +++++
 rtl/seq_alu.sv | 188 ++++++++++++++++++
 tb/tb_seq_alu.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, flag bundle and FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_XOR  = 3'd3,
        OP_SHR  = 3'd4,
        OP_LDUI = 3'd5,
        OP_MUL  = 3'd6
    } alu_op_e;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } flags_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2,
        ST_DONE  = 2'd3
    } alu_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU ops (ADD/SUB/AND/XOR/LDUI) with flag generation.
// Any other opcode yields the illegal-op result: d = 0, z = 1.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_d,
    output flags_t           o_flags
);

    alu_op_e          w_op;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [WIDTH-1:0] w_d;
    logic             w_c;
    logic             w_v;

    assign w_op  = alu_op_e'(i_op);
    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    // The extra top bit of the difference is the borrow (set iff a <u b).
    assign w_dif = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        w_d = '0;
        w_c = 1'b0;
        w_v = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_d = w_sum[WIDTH-1:0];
                w_c = w_sum[WIDTH];
                w_v = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_d = w_dif[WIDTH-1:0];
                w_c = w_dif[WIDTH];
                w_v = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_dif[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND:  w_d = i_a & i_b;
            OP_XOR:  w_d = i_a ^ i_b;
            OP_LDUI: w_d = {i_b[WIDTH/2-1:0], i_a[WIDTH/2-1:0]};
            default: w_d = '0;
        endcase
    end

    assign o_d       = w_d;
    assign o_flags.z = (w_d == '0);
    assign o_flags.c = w_c;
    assign o_flags.n = w_d[WIDTH-1];
    assign o_flags.v = w_v;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: valid/ready handshake, 1-bit/cycle shifter with signed amount,
// optional shift-add multiplier enabled by the ALU_MUL_EN macro.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] s1,
    input  logic [WIDTH-1:0] s2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output flags_t           flags
);

    localparam int LW = $clog2(WIDTH);
    localparam int CW = LW + 1;

    alu_state_e       r_state;
    alu_state_e       w_next;
    logic [WIDTH-1:0] r_d;
    flags_t           r_flags;
    logic [WIDTH-1:0] r_work;
    logic             r_left;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_core_d;
    flags_t           w_core_flags;
    logic [LW-1:0]    w_mag;
    logic             w_is_shr;
    logic             w_last;
    logic [WIDTH-1:0] w_sh_next;
    logic             w_sh_out;

`ifdef ALU_MUL_EN
    logic               w_is_mul;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_is_mul = (op == OP_MUL);
    // Low half of the accumulator starts as the multiplier; its LSB selects each partial product.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_mcand : {WIDTH{1'b0}})};
    assign w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
`endif

    function automatic flags_t mk_flags(input logic [WIDTH-1:0] val, input logic carry);
        flags_t f;
        f.z = (val == '0);
        f.c = carry;
        f.n = val[WIDTH-1];
        f.v = 1'b0;
        return f;
    endfunction

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .i_op   (op),
        .i_a    (s1),
        .i_b    (s2),
        .o_d    (w_core_d),
        .o_flags(w_core_flags)
    );

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign d         = r_d;
    assign flags     = r_flags;

    assign w_is_shr = (op == OP_SHR);
    // Negative shift control means a left shift by the two's-complement magnitude mod WIDTH.
    assign w_mag    = s2[WIDTH-1] ? (~s2[LW-1:0] + LW'(1)) : s2[LW-1:0];
    assign w_last   = (r_cnt == CW'(1));

    assign w_sh_next = r_left ? {r_work[WIDTH-2:0], 1'b0} : {1'b0, r_work[WIDTH-1:1]};
    assign w_sh_out  = r_left ? r_work[WIDTH-1] : r_work[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (w_is_shr && (w_mag != '0)) begin
                        w_next = ST_SHIFT;
                    end
`ifdef ALU_MUL_EN
                    else if (w_is_mul) begin
                        w_next = ST_MUL;
                    end
`endif
                    else begin
                        w_next = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
`ifdef ALU_MUL_EN
            ST_MUL: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Result registers only change when a result is produced, so they hold through backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d     <= '0;
            r_flags <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_work <= s1;
                        r_left <= s2[WIDTH-1];
                        r_cnt  <= CW'(w_mag);
                        if (w_is_shr) begin
                            if (w_mag == '0) begin
                                r_d     <= s1;
                                r_flags <= mk_flags(s1, 1'b0);
                            end
                        end
`ifdef ALU_MUL_EN
                        else if (w_is_mul) begin
                            r_mcand <= s1;
                            r_acc   <= {{WIDTH{1'b0}}, s2};
                            r_cnt   <= CW'(WIDTH);
                        end
`endif
                        else begin
                            r_d     <= w_core_d;
                            r_flags <= w_core_flags;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_work <= w_sh_next;
                    r_cnt  <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_d     <= w_sh_next;
                        r_flags <= mk_flags(w_sh_next, w_sh_out);
                    end
                end
`ifdef ALU_MUL_EN
                ST_MUL: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_d     <= w_acc_next[WIDTH-1:0];
                        r_flags <= mk_flags(w_acc_next[WIDTH-1:0], |w_acc_next[2*WIDTH-1:WIDTH]);
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=16); MUL expectations follow ALU_MUL_EN.
module tb_seq_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [15:0] s1 = 16'h0;
    logic [15:0] s2 = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] d;
    flags_t      flg;

    int n_cmp = 0;
    int n_err = 0;

    seq_alu #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .s1       (s1),
        .s2       (s2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .d        (d),
        .flags    (flg)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op with out_ready high, measure latency, check result and the handshake drop.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_d,
                          input logic [3:0] exp_f, input int exp_lat);
        int lat;
        @(negedge clk);
        op = o; s1 = a; s2 = b; in_valid = 1'b1; out_ready = 1'b1;
        check_val({tag, ".rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; op = 3'd0; s1 = ~a; s2 = ~b;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, ".d"}, 32'(d), 32'(exp_d));
        check_val({tag, ".flags"}, 32'(flg), 32'(exp_f));
        @(posedge clk); #1;
        check_val({tag, ".vld_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("rst.in_ready", 32'(in_ready), 32'd1);
        check_val("rst.out_valid", 32'(out_valid), 32'd0);
        check_val("rst.d", 32'(d), 32'd0);
        check_val("rst.flags", 32'(flg), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        //                 op       s1        s2        d         zcnv     lat
        run_op("add_ovf",  OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 4'b0011, 1);
        run_op("add_cy",   OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 4'b1100, 1);
        run_op("sub_brw",  OP_SUB,  16'h0000, 16'h0001, 16'hFFFF, 4'b0110, 1);
        run_op("sub_ovf",  OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1);
        run_op("sub_pos",  OP_SUB,  16'h0005, 16'h0003, 16'h0002, 4'b0000, 1);
        run_op("and",      OP_AND,  16'hF0F0, 16'h0F0F, 16'h0000, 4'b1000, 1);
        run_op("xor",      OP_XOR,  16'hFFFF, 16'h0F0F, 16'hF0F0, 4'b0010, 1);
        run_op("ldui",     OP_LDUI, 16'h12AB, 16'h34CD, 16'hCDAB, 4'b0010, 1);
        run_op("shr3",     OP_SHR,  16'h8001, 16'h0003, 16'h1000, 4'b0000, 4);
        run_op("shl1",     OP_SHR,  16'h8001, 16'hFFFF, 16'h0002, 4'b0100, 2);
        run_op("shr15",    OP_SHR,  16'h8001, 16'h000F, 16'h0001, 4'b0000, 16);
        run_op("shl15",    OP_SHR,  16'h0003, 16'h8001, 16'h8000, 4'b0110, 16);
        run_op("sh0",      OP_SHR,  16'h8001, 16'h0000, 16'h8001, 4'b0010, 1);
        run_op("sh0_neg",  OP_SHR,  16'h0042, 16'hFFF0, 16'h0042, 4'b0000, 1);
        run_op("illegal",  3'd7,    16'h0005, 16'h0003, 16'h0000, 4'b1000, 1);
`ifdef ALU_MUL_EN
        run_op("mul_hi",   OP_MUL,  16'h0100, 16'h0100, 16'h0000, 4'b1100, 17);
        run_op("mul_lo",   OP_MUL,  16'h0003, 16'h0005, 16'h000F, 4'b0000, 17);
`else
        run_op("mul_hi",   OP_MUL,  16'h0100, 16'h0100, 16'h0000, 4'b1000, 1);
        run_op("mul_lo",   OP_MUL,  16'h0003, 16'h0005, 16'h0000, 4'b1000, 1);
`endif

        // Backpressure: result held for 5 cycles while a stray in_valid pulse arrives.
        @(negedge clk);
        op = OP_ADD; s1 = 16'h1234; s2 = 16'h0101; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("bp.vld", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i == 2); op = OP_SUB; s1 = 16'h0000; s2 = 16'h0001;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check_val("bp.d", 32'(d), 32'h1335);
            check_val("bp.flags", 32'(flg), 32'h0);
            check_val("bp.in_ready", 32'(in_ready), 32'd0);
            check_val("bp.out_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_val("bp.drop", 32'(out_valid), 32'd0);
        check_val("bp.idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check_val("bp.no_accept", 32'(out_valid), 32'd0);
        check_val("bp.d_kept", 32'(d), 32'h1335);

        // Reset in the middle of an 8-bit shift, then reset colliding with in_valid.
        @(negedge clk);
        op = OP_SHR; s1 = 16'hFFFF; s2 = 16'h0008; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; op = OP_ADD; s1 = 16'h0001; s2 = 16'h0001;
        @(posedge clk); #1;
        check_val("rst_mid.out_valid", 32'(out_valid), 32'd0);
        check_val("rst_mid.in_ready", 32'(in_ready), 32'd1);
        check_val("rst_mid.d", 32'(d), 32'd0);
        check_val("rst_mid.flags", 32'(flg), 32'd0);
        @(posedge clk); #1;
        check_val("rst_vs_valid", 32'(out_valid), 32'd0);
        check_val("rst_vs_valid.d", 32'(d), 32'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        run_op("post_rst", OP_ADD, 16'h0001, 16'h0002, 16'h0003, 4'b0000, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
